state_stepper: RTL and testbench

Sequencer that drives the `next_state` strobe of the instruction-state counter (StateManager). It sits directly upstream of that counter and consumes the `state` value the counter produces. For each state value it:
- optionally performs one memory bus handshake,
- enforces a minimum dwell time,
- then pulses `next_state` for exactly one cycle.

It also supports halt, bus timeout with error lock-up, and counts retired instructions on state wrap-around.

---
 rtl/state_stepper_pkg.sv | 27 ++
 rtl/state_stepper_if.sv | 9 +
 rtl/state_stepper_watchdog.sv | 26 ++
 rtl/state_stepper.sv | 165 ++++++++++++++++
 tb/tb_state_stepper.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/state_stepper_pkg.sv
// Shared encodings for the instruction-state sequencer: FSM state codes and
// the width of the retired-instruction counter.
package state_stepper_pkg;

  localparam logic [2:0] SSTEP_EVAL  = 3'd0;
  localparam logic [2:0] SSTEP_REQ   = 3'd1;
  localparam logic [2:0] SSTEP_DWELL = 3'd2;
  localparam logic [2:0] SSTEP_STEP  = 3'd3;
  localparam logic [2:0] SSTEP_HALT  = 3'd4;
  localparam logic [2:0] SSTEP_ERR   = 3'd5;

  localparam int RETIRED_W = 16;

  typedef enum logic [2:0] {
    S_EVAL  = SSTEP_EVAL,
    S_REQ   = SSTEP_REQ,
    S_DWELL = SSTEP_DWELL,
    S_STEP  = SSTEP_STEP,
    S_HALT  = SSTEP_HALT,
    S_ERR   = SSTEP_ERR
  } sstep_e;

  function automatic logic is_idle(input sstep_e s);
    return (s == S_EVAL) || (s == S_HALT);
  endfunction

endpackage

// File: rtl/state_stepper_if.sv
// Memory bus handshake between the sequencer (master) and the memory (slave).
interface state_stepper_if;
  logic mem_req;
  logic mem_we;
  logic mem_ack;

  modport master (output mem_req, output mem_we, input mem_ack);
  modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/state_stepper_watchdog.sv
// Bus wait counter: expired rises in the TIMEOUT-th consecutive cycle of run.
// Only instantiated when STATE_STEPPER_TIMEOUT_EN is defined.
module step_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expired
);
  logic [7:0] cnt_q, cnt_d;

  assign expired = run && (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (run && !expired) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/state_stepper.sv
// Drives the next_state strobe of the instruction-state counter: optional bus
// access, dwell, one-cycle step. Bus timeout/error lock-up under STATE_STEPPER_TIMEOUT_EN.
module state_stepper
  import state_stepper_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int DWELL   = 0,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STATE_W-1:0]   state,
  input  logic                 need_mem,
  input  logic                 mem_wr_i,
  input  logic                 halt,
  state_stepper_if.master      bus,
  output logic                 next_state,
  output logic                 busy,
  output logic                 bus_err,
  output logic                 instr_done,
  output logic [RETIRED_W-1:0] retired
);

  if (DWELL < 0 || DWELL > 15) begin : g_bad_dwell
    $error("state_stepper: DWELL must be 0..15");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("state_stepper: TIMEOUT must be 2..255");
  end

  sstep_e               fsm_q, fsm_d;
  logic                 next_state_q, next_state_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic                 busy_q, busy_d;
  logic                 instr_done_q, instr_done_d;
  logic [RETIRED_W-1:0] retired_q, retired_d;
  logic [3:0]           dwell_q, dwell_d;
  logic                 go_step;
  logic                 wrap;

  assign wrap = &state;

`ifdef STATE_STEPPER_TIMEOUT_EN
  logic wd_run, wd_expired;
  logic bus_err_q, bus_err_d;

  assign wd_run = (fsm_q == S_REQ);

  step_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .run     (wd_run),
    .clr     (!wd_run),
    .expired (wd_expired)
  );

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  always_comb begin
    fsm_d        = fsm_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    dwell_d      = dwell_q;
    retired_d    = retired_q;
    next_state_d = 1'b0;
    instr_done_d = 1'b0;
    go_step      = 1'b0;
`ifdef STATE_STEPPER_TIMEOUT_EN
    bus_err_d    = bus_err_q;
`endif
    case (fsm_q)
      S_EVAL: begin
        if (halt) begin
          fsm_d = S_HALT;
        end else if (need_mem) begin
          mem_req_d = 1'b1;
          mem_we_d  = mem_wr_i;
          fsm_d     = S_REQ;
        end else if (DWELL > 0) begin
          dwell_d = 4'(DWELL);
          fsm_d   = S_DWELL;
        end else begin
          go_step = 1'b1;
        end
      end
      S_REQ: begin
        // ack wins over a same-cycle timeout: the transfer did complete
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (DWELL > 0) begin
            dwell_d = 4'(DWELL);
            fsm_d   = S_DWELL;
          end else begin
            go_step = 1'b1;
          end
        end
`ifdef STATE_STEPPER_TIMEOUT_EN
        else if (wd_expired) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = 1'b1;
          fsm_d     = S_ERR;
        end
`endif
      end
      S_DWELL: begin
        if (dwell_q == 4'd1) go_step = 1'b1;
        else                 dwell_d = dwell_q - 4'd1;
      end
      S_STEP:  fsm_d = S_EVAL;
      S_HALT:  if (!halt) fsm_d = S_EVAL;
      default: ; // S_ERR: locked until reset
    endcase

    // outputs are registered, so the step's strobes are set on entry to S_STEP
    if (go_step) begin
      fsm_d        = S_STEP;
      next_state_d = 1'b1;
      instr_done_d = wrap;
      retired_d    = retired_q + {{(RETIRED_W-1){1'b0}}, wrap};
    end
    busy_d = !is_idle(fsm_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= S_EVAL;
      next_state_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      instr_done_q <= 1'b0;
      retired_q    <= '0;
      dwell_q      <= '0;
`ifdef STATE_STEPPER_TIMEOUT_EN
      bus_err_q    <= 1'b0;
`endif
    end else begin
      fsm_q        <= fsm_d;
      next_state_q <= next_state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
      instr_done_q <= instr_done_d;
      retired_q    <= retired_d;
      dwell_q      <= dwell_d;
`ifdef STATE_STEPPER_TIMEOUT_EN
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  assign next_state  = next_state_q;
  assign bus.mem_req = mem_req_q;
  assign bus.mem_we  = mem_we_q;
  assign busy        = busy_q;
  assign instr_done  = instr_done_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_state_stepper.sv
// Bench for state_stepper: a 4-bit state counter plus a per-state timing
// model (eval, k request cycles, DWELL idle cycles, one step cycle).
module tb_state_stepper;
  localparam int DW = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  st  = 4'd0;
  logic        need_mem = 1'b0, mem_wr_i = 1'b0, halt = 1'b0;
  logic        next_state, busy, bus_err, instr_done;
  logic [15:0] retired;

  state_stepper_if bus();

  state_stepper #(.STATE_W(4), .DWELL(DW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (st),
    .need_mem   (need_mem),
    .mem_wr_i   (mem_wr_i),
    .halt       (halt),
    .bus        (bus.master),
    .next_state (next_state),
    .busy       (busy),
    .bus_err    (bus_err),
    .instr_done (instr_done),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // instruction-state counter: steps on negedge when strobed
  always @(negedge clk) begin
    if (rst)             st <= 4'd0;
    else if (next_state) st <= st + 4'd1;
  end

  int n_chk = 0;
  int n_fail = 0;
  int exp_st = 0;
  int exp_ret = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One whole state, starting in its evaluation cycle.
  task automatic run_state(input bit need, input bit wr, input int k, input bit raise_halt);
    bit wrap;
    wrap = (exp_st == 15);
    check("eval_ns", next_state, 0);
    check("eval_req", bus.mem_req, 0);
    check("eval_busy", busy, 0);
    check("state", st, exp_st);
    check("retired", retired, exp_ret);
    need_mem = need;
    mem_wr_i = wr;
    bus.mem_ack = 1'($urandom_range(0, 1));
    tick();
    if (need) begin
      for (int i = 1; i <= k; i++) begin
        check("req", bus.mem_req, 1);
        check("req_we", bus.mem_we, wr);
        check("req_ns", next_state, 0);
        check("req_busy", busy, 1);
        need_mem = 1'($urandom_range(0, 1));
        mem_wr_i = 1'($urandom_range(0, 1));
        if (raise_halt) halt = 1'b1;
        bus.mem_ack = (i == k);
        tick();
      end
    end
    for (int d = 0; d < DW; d++) begin
      check("dwell_ns", next_state, 0);
      check("dwell_req", bus.mem_req, 0);
      check("dwell_busy", busy, 1);
      bus.mem_ack = 1'($urandom_range(0, 1));
      tick();
    end
    check("step_ns", next_state, 1);
    check("step_req", bus.mem_req, 0);
    check("step_done", instr_done, wrap);
    check("step_ret", retired, exp_ret + int'(wrap));
    check("step_err", bus_err, 0);
    bus.mem_ack = 1'($urandom_range(0, 1));
    tick();
    bus.mem_ack = 1'b0;
    exp_st  = (exp_st + 1) % 16;
    exp_ret = exp_ret + int'(wrap);
  endtask

  task automatic run_random(input int n);
    for (int s = 0; s < n; s++)
      run_state(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 5), 1'b0);
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ns", next_state, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_err", bus_err, 0);
    check("rst_done", instr_done, 0);
    check("rst_ret", retired, 0);
    rst = 1'b0;

    // past one wrap of the 4-bit counter
    run_random(20);
    check("ret_after_wrap", retired, 1);

    // write access acked in the third request cycle
    run_state(1'b1, 1'b1, 3, 1'b0);
    run_state(1'b1, 1'b0, 1, 1'b0);
    run_state(1'b0, 1'b0, 1, 1'b0);

    // halt raised mid-request: access and step complete, then hold
    run_state(1'b1, 1'b1, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("halt_ns", next_state, 0);
      check("halt_busy", busy, 0);
      check("halt_req", bus.mem_req, 0);
      need_mem = 1'b1;
      tick();
    end
    halt = 1'b0;
    check("release_ns", next_state, 0);
    tick();
    run_state(1'b0, 1'b0, 1, 1'b0);
    run_random(4);

    // reset in the middle of an unacked request
    need_mem = 1'b1;
    mem_wr_i = 1'b1;
    bus.mem_ack = 1'b0;
    tick();
    check("mid_req1", bus.mem_req, 1);
    tick();
    check("mid_req2", bus.mem_req, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_req", bus.mem_req, 0);
    check("mid_rst_we", bus.mem_we, 0);
    check("mid_rst_ns", next_state, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ret", retired, 0);
    rst = 1'b0;
    exp_st = 0;
    exp_ret = 0;
    run_random(18);

`ifdef STATE_STEPPER_TIMEOUT_EN
    // no ack: request held TO cycles, then sticky error
    need_mem = 1'b1;
    mem_wr_i = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
    for (int i = 1; i <= TO; i++) begin
      check("to_req", bus.mem_req, 1);
      check("to_err_low", bus_err, 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check("err_req", bus.mem_req, 0);
      check("err_flag", bus_err, 1);
      check("err_ns", next_state, 0);
      check("err_done", instr_done, 0);
      bus.mem_ack = 1'b1;
      tick();
    end
    bus.mem_ack = 1'b0;
    rst = 1'b1;
    tick();
    check("err_rst_flag", bus_err, 0);
    check("err_rst_req", bus.mem_req, 0);
    check("err_rst_busy", busy, 0);
    check("err_rst_ret", retired, 0);
    rst = 1'b0;
    exp_st = 0;
    exp_ret = 0;
    run_random(3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
